// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline sequencer.
// Holds the FSM state encoding and the MRET/SRET cause codes that decode also uses.
// Optional feature macro: PIPE_CTRL_PERF_EN (left undefined here; define it on the
// command line to build the performance counters).
package pipe_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StDrain   = 2'b01,
        StRefetch = 2'b10,
        StTrap    = 2'b11
    } state_e;

    localparam int unsigned CntW = 4;

    // Internal cause codes decode raises for xRET, above the architectural exception range
    localparam logic [63:0] CauseMret = 64'd32;
    localparam logic [63:0] CauseSret = 64'd33;

    // Redirect target of a trap or xRET
    function automatic logic [63:0] trap_target(input logic [63:0] cause,
                                                input logic [63:0] mtvec,
                                                input logic [63:0] mepc,
                                                input logic [63:0] sepc);
        logic [63:0] tgt;
        tgt = mtvec;
        if (cause == CauseMret) begin
            tgt = mepc;
        end else if (cause == CauseSret) begin
            tgt = sepc;
        end
        return tgt;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: stall, flush and trap event counters for the pipeline sequencer.
// Only compiled when PIPE_CTRL_PERF_EN is defined; counters wrap at 2^64.
`ifdef PIPE_CTRL_PERF_EN
module pipe_perf_cnt (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        trap_enter_i,
    output logic [63:0] stall_cnt_o,
    output logic [63:0] flush_cnt_o,
    output logic [63:0] trap_cnt_o
);

    logic [63:0] stall_cnt_d, stall_cnt_q;
    logic [63:0] flush_cnt_d, flush_cnt_q;
    logic [63:0] trap_cnt_d, trap_cnt_q;

    // Next counts: bump each counter on its event
    always_comb begin
        stall_cnt_d = stall_cnt_q + {63'd0, stall_i};
        flush_cnt_d = flush_cnt_q + {63'd0, flush_i};
        trap_cnt_d  = trap_cnt_q + {63'd0, trap_enter_i};
    end

    // Counter registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            trap_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            trap_cnt_q  <= trap_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign trap_cnt_o  = trap_cnt_q;

endmodule
`endif

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline sequencer for the five-stage rv64 core.
// Turns decode hazard/control-flow requests and EX/MEM busy signals into per-stage
// stall/flush and fetch redirect. Fence drain/refetch and trap/xRET redirect are
// sequenced by a small FSM. Optional macro PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FENCE_CYCLES = 3  // legal 1..15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_use_i,
    input  logic        branch_flush_i,
    input  logic        fence_i,
    input  logic        exception_i,
    input  logic [63:0] cause_i,
    input  logic [63:0] pc_i,
    input  logic [63:0] mtvec_i,
    input  logic [63:0] mepc_i,
    input  logic [63:0] sepc_i,
    input  logic        ex_busy_i,
    input  logic        mem_busy_i,
    output logic        stall_if_o,
    output logic        stall_id_o,
    output logic        stall_ex_o,
    output logic        stall_mem_o,
    output logic        flush_id_o,
    output logic        flush_ex_o,
    output logic        redirect_o,
    output logic [63:0] redirect_pc_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [63:0] perf_stall_cnt_o,
    output logic [63:0] perf_flush_cnt_o,
    output logic [63:0] perf_trap_cnt_o,
`endif
    output logic        busy_o
);

    localparam logic [CntW-1:0] CntLoad = CntW'(FENCE_CYCLES - 1);

    state_e            state_d, state_q;
    logic [CntW-1:0]   cnt_d, cnt_q;
    logic [63:0]       tgt_d, tgt_q;     // latched trap/xRET target
    logic [63:0]       fpc_d, fpc_q;     // latched fence pc+4

    logic        stall_if, stall_id, stall_ex, stall_mem;
    logic        flush_id_raw, flush_ex_raw;
    logic        redirect;
    logic [63:0] redirect_pc;

    // Next-state, latches and raw stage controls
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tgt_d        = tgt_q;
        fpc_d        = fpc_q;
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        stall_ex     = 1'b0;
        stall_mem    = 1'b0;
        flush_id_raw = 1'b0;
        flush_ex_raw = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = '0;

        unique case (state_q)
            StRun: begin
                if (mem_busy_i) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    stall_mem = 1'b1;
                end else if (ex_busy_i) begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    stall_ex = 1'b1;
                end else if (exception_i) begin
                    flush_id_raw = 1'b1;
                    flush_ex_raw = 1'b1;
                    tgt_d        = trap_target(cause_i, mtvec_i, mepc_i, sepc_i);
                    state_d      = StTrap;
                end else if (fence_i) begin
                    stall_if     = 1'b1;
                    stall_id     = 1'b1;
                    flush_ex_raw = 1'b1;
                    cnt_d        = CntLoad;
                    fpc_d        = pc_i + 64'd4;
                    state_d      = StDrain;
                end else if (load_use_i) begin
                    stall_if     = 1'b1;
                    stall_id     = 1'b1;
                    flush_ex_raw = 1'b1;
                end else if (branch_flush_i) begin
                    // ifetch already has the branch target, no redirect needed
                    flush_id_raw = 1'b1;
                end
            end
            StDrain: begin
                // Decode requests are ignored while older instructions drain
                stall_if     = 1'b1;
                stall_id     = 1'b1;
                flush_ex_raw = 1'b1;
                stall_mem    = mem_busy_i;
                if (!mem_busy_i) begin
                    if (cnt_q == '0) begin
                        state_d = StRefetch;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            StRefetch: begin
                redirect     = 1'b1;
                redirect_pc  = fpc_q;
                flush_id_raw = 1'b1;
                state_d      = StRun;
            end
            StTrap: begin
                redirect     = 1'b1;
                redirect_pc  = tgt_q;
                flush_id_raw = 1'b1;
                state_d      = StRun;
            end
        endcase
    end

    // State and latch registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StRun;
            cnt_q   <= '0;
            tgt_q   <= '0;
            fpc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            fpc_q   <= fpc_d;
        end
    end

    // Output stage: stall beats flush on the same stage, everything low in reset
    always_comb begin
        stall_if_o    = rst_ni & stall_if;
        stall_id_o    = rst_ni & stall_id;
        stall_ex_o    = rst_ni & stall_ex;
        stall_mem_o   = rst_ni & stall_mem;
        flush_id_o    = rst_ni & flush_id_raw & ~stall_id;
        flush_ex_o    = rst_ni & flush_ex_raw & ~stall_ex;
        redirect_o    = rst_ni & redirect;
        redirect_pc_o = rst_ni ? redirect_pc : '0;
        busy_o        = rst_ni & (state_q != StRun);
    end

`ifdef PIPE_CTRL_PERF_EN
    logic        trap_enter;
    logic [63:0] perf_stall_cnt, perf_flush_cnt, perf_trap_cnt;

    assign trap_enter = (state_q == StRun) && (state_d == StTrap);

    pipe_perf_cnt u_perf (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .stall_i      (stall_if_o),
        .flush_i      (flush_id_o),
        .trap_enter_i (trap_enter),
        .stall_cnt_o  (perf_stall_cnt),
        .flush_cnt_o  (perf_flush_cnt),
        .trap_cnt_o   (perf_trap_cnt)
    );

    // Perf outputs also read zero while reset is held
    always_comb begin
        perf_stall_cnt_o = rst_ni ? perf_stall_cnt : '0;
        perf_flush_cnt_o = rst_ni ? perf_flush_cnt : '0;
        perf_trap_cnt_o  = rst_ni ? perf_trap_cnt : '0;
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a behavioural model.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int unsigned FC = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_use, branch_flush, fence, exception, ex_busy, mem_busy;
    logic [63:0] cause, pc, mtvec, mepc, sepc;
    logic        stall_if_o, stall_id_o, stall_ex_o, stall_mem_o;
    logic        flush_id_o, flush_ex_o, redirect_o, busy_o;
    logic [63:0] redirect_pc_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [63:0] perf_stall_cnt_o, perf_flush_cnt_o, perf_trap_cnt_o;
`endif

    always #5 clk = ~clk;

    pipe_ctrl #(.FENCE_CYCLES(FC)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .load_use_i     (load_use),
        .branch_flush_i (branch_flush),
        .fence_i        (fence),
        .exception_i    (exception),
        .cause_i        (cause),
        .pc_i           (pc),
        .mtvec_i        (mtvec),
        .mepc_i         (mepc),
        .sepc_i         (sepc),
        .ex_busy_i      (ex_busy),
        .mem_busy_i     (mem_busy),
        .stall_if_o     (stall_if_o),
        .stall_id_o     (stall_id_o),
        .stall_ex_o     (stall_ex_o),
        .stall_mem_o    (stall_mem_o),
        .flush_id_o     (flush_id_o),
        .flush_ex_o     (flush_ex_o),
        .redirect_o     (redirect_o),
        .redirect_pc_o  (redirect_pc_o),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_flush_cnt_o (perf_flush_cnt_o),
        .perf_trap_cnt_o  (perf_trap_cnt_o),
`endif
        .busy_o         (busy_o)
    );

    int checks = 0;
    int errors = 0;

    // Model state: pending work expressed as "what happens next", not as FSM states
    int          m_drain_left;   // non-busy drain cycles still owed
    bit          m_refetch_due;
    bit          m_trap_due;
    logic [63:0] m_refetch_pc, m_trap_pc;
    longint unsigned m_stall_cnt, m_flush_cnt, m_trap_cnt;

    bit          e_sif, e_sid, e_sex, e_smem, e_fid, e_fex, e_redir, e_busy;
    logic [63:0] e_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_eval();
        {e_sif, e_sid, e_sex, e_smem, e_fid, e_fex, e_redir, e_busy} = '0;
        e_pc = '0;
        if (!rst_n) return;
        if (m_trap_due || m_refetch_due) begin
            e_redir = 1;
            e_pc    = m_trap_due ? m_trap_pc : m_refetch_pc;
            e_fid   = 1;
            e_busy  = 1;
        end else if (m_drain_left > 0) begin
            e_sif  = 1;
            e_sid  = 1;
            e_fex  = 1;
            e_smem = mem_busy;
            e_busy = 1;
        end else if (mem_busy) begin
            {e_sif, e_sid, e_sex, e_smem} = 4'hf;
        end else if (ex_busy) begin
            {e_sif, e_sid, e_sex} = 3'h7;
        end else if (exception) begin
            e_fid = 1;
            e_fex = 1;
        end else if (fence || load_use) begin
            e_sif = 1;
            e_sid = 1;
            e_fex = 1;
        end else if (branch_flush) begin
            e_fid = 1;
        end
        if (e_sid) e_fid = 0;
        if (e_sex) e_fex = 0;
    endtask

    task automatic compare_all();
        chk("stall_if", stall_if_o, e_sif);
        chk("stall_id", stall_id_o, e_sid);
        chk("stall_ex", stall_ex_o, e_sex);
        chk("stall_mem", stall_mem_o, e_smem);
        chk("flush_id", flush_id_o, e_fid);
        chk("flush_ex", flush_ex_o, e_fex);
        chk("redirect", redirect_o, e_redir);
        chk("busy", busy_o, e_busy);
        if (e_redir) chk("redirect_pc", redirect_pc_o, e_pc);
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall", perf_stall_cnt_o, rst_n ? m_stall_cnt : 64'd0);
        chk("perf_flush", perf_flush_cnt_o, rst_n ? m_flush_cnt : 64'd0);
        chk("perf_trap", perf_trap_cnt_o, rst_n ? m_trap_cnt : 64'd0);
`endif
    endtask

    task automatic model_update();
        bool_t_dummy();
        if (!rst_n) begin
            m_drain_left = 0;
            m_refetch_due = 0;
            m_trap_due = 0;
            m_stall_cnt = 0;
            m_flush_cnt = 0;
            m_trap_cnt = 0;
            return;
        end
        m_stall_cnt += longint'(e_sif);
        m_flush_cnt += longint'(e_fid);
        if (m_trap_due || m_refetch_due) begin
            m_trap_due = 0;
            m_refetch_due = 0;
        end else if (m_drain_left > 0) begin
            if (!mem_busy) begin
                m_drain_left--;
                if (m_drain_left == 0) m_refetch_due = 1;
            end
        end else if (!mem_busy && !ex_busy) begin
            if (exception) begin
                m_trap_due = 1;
                m_trap_cnt++;
                if (cause == CauseMret) m_trap_pc = mepc;
                else if (cause == CauseSret) m_trap_pc = sepc;
                else m_trap_pc = mtvec;
            end else if (fence) begin
                m_drain_left = FC;
                m_refetch_pc = pc + 64'd4;
            end
        end
    endtask

    task automatic bool_t_dummy();
    endtask

    // Sample on the falling edge, then let the model take the rising edge
    task automatic sample();
        @(negedge clk);
        model_eval();
        compare_all();
    endtask

    task automatic advance();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {load_use, branch_flush, fence, exception, ex_busy, mem_busy} = '0;
        cause = 64'h0;
        pc    = 64'h0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        mtvec = 64'h8000_0000;
        mepc  = 64'h0;
        sepc  = 64'h0;
        m_drain_left = 0;
        m_refetch_due = 0;
        m_trap_due = 0;
        m_refetch_pc = '0;
        m_trap_pc = '0;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
        m_trap_cnt = 0;
        @(posedge clk);
        #1;

        // Reset: everything low
        load_use = 1;
        fence = 1;
        sample();
        chk("reset_outputs", {stall_if_o, stall_id_o, stall_ex_o, stall_mem_o, flush_id_o,
                              flush_ex_o, redirect_o, busy_o}, 8'h00);
        chk("reset_pc", redirect_pc_o, 64'h0);
        advance();
        idle();
        rst_n = 1'b1;

        // Load-use for one cycle
        load_use = 1;
        sample();
        chk("lu_stall_if", stall_if_o, 1);
        chk("lu_stall_id", stall_id_o, 1);
        chk("lu_flush_ex", flush_ex_o, 1);
        advance();
        idle();
        sample();
        chk("lu_after_stall_if", stall_if_o, 0);
        chk("lu_after_flush_ex", flush_ex_o, 0);
        advance();

        // Fence: entry, FC drain cycles, one refetch
        fence = 1;
        pc = 64'h8000_0010;
        sample();
        chk("fence_entry_stall_if", stall_if_o, 1);
        chk("fence_entry_flush_ex", flush_ex_o, 1);
        advance();
        idle();
        for (int i = 0; i < 3; i++) begin
            sample();
            chk("fence_drain_stall_id", stall_id_o, 1);
            chk("fence_drain_redirect", redirect_o, 0);
            advance();
        end
        sample();
        chk("fence_refetch", redirect_o, 1);
        chk("fence_refetch_pc", redirect_pc_o, 64'h8000_0014);
        chk("fence_refetch_flush_id", flush_id_o, 1);
        advance();
        sample();
        chk("fence_done_busy", busy_o, 0);
        chk("fence_done_redirect", redirect_o, 0);
        advance();

        // MRET
        exception = 1;
        cause = CauseMret;
        mepc = 64'h8000_0100;
        sepc = 64'h8000_0200;
        sample();
        chk("mret_flush_id", flush_id_o, 1);
        chk("mret_flush_ex", flush_ex_o, 1);
        chk("mret_n_redirect", redirect_o, 0);
        advance();
        idle();
        sample();
        chk("mret_redirect", redirect_o, 1);
        chk("mret_pc", redirect_pc_o, 64'h8000_0100);
        advance();
        sample();
        chk("mret_one_shot", redirect_o, 0);
        advance();

        // Exception beats load-use and branch
        exception = 1;
        load_use = 1;
        branch_flush = 1;
        cause = 64'h2;
        sample();
        chk("prio_stall_if", stall_if_o, 0);
        chk("prio_flush_id", flush_id_o, 1);
        advance();
        idle();
        sample();
        chk("prio_redirect_pc", redirect_pc_o, 64'h8000_0000);
        advance();

        // mem_busy for two cycles while the last drain cycle is owed
        fence = 1;
        pc = 64'hffff_ffff_ffff_fffc;
        sample();
        advance();
        idle();
        for (int i = 0; i < 7; i++) begin
            mem_busy = (i == 2 || i == 3);
            sample();
            if (i == 2 || i == 3) chk("membusy_stall_mem", stall_mem_o, 1);
            if (i == 3 || i == 4) chk("membusy_no_refetch", redirect_o, 0);
            if (i == 5) begin
                chk("membusy_refetch", redirect_o, 1);
                chk("wrap_pc", redirect_pc_o, 64'h0);
            end
            advance();
        end
        idle();

        // Reset right after fence entry
        fence = 1;
        pc = 64'h8000_0040;
        sample();
        advance();
        idle();
        rst_n = 1'b0;
        sample();
        chk("midfence_reset_stall", stall_if_o, 0);
        chk("midfence_reset_busy", busy_o, 0);
        advance();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("midfence_no_redirect", redirect_o, 0);
            advance();
        end

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            rst_n        = ($urandom_range(0, 99) >= 2);
            mem_busy     = ($urandom_range(0, 99) < 15);
            ex_busy      = ($urandom_range(0, 99) < 12);
            exception    = ($urandom_range(0, 99) < 6);
            fence        = ($urandom_range(0, 99) < 8);
            load_use     = ($urandom_range(0, 99) < 20);
            branch_flush = ($urandom_range(0, 99) < 25) && !load_use;
            case ($urandom_range(0, 3))
                0: cause = CauseMret;
                1: cause = CauseSret;
                default: cause = {32'h0, $urandom};
            endcase
            pc    = ($urandom_range(0, 9) == 0) ? 64'hffff_ffff_ffff_fffc : {$urandom, $urandom};
            mtvec = {$urandom, $urandom};
            mepc  = {$urandom, $urandom};
            sepc  = {$urandom, $urandom};
            sample();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
